serial_comparator: RTL and testbench

- Bit-serial N-bit magnitude/equality comparator built around the 1-bit equality stage.
- Loads two N-bit operands on `start`, shifts them out MSB-first one bit per clock, and evaluates equality (A XNOR B) each cycle.
- The first differing bit decides the result. Reports eq/gt/lt with a busy/done handshake.
- Sits between operand sources (switches/registers) and downstream display or control logic.

---
 rtl/serial_comparator_if.sv | 25 ++
 rtl/serial_comparator.sv | 109 ++++++++++
 tb/tb_serial_comparator.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_if.sv
// Operand/result bundle for the bit-serial comparator.
// The source side (master) drives start and the operands.
// The comparator (slave) returns busy/done and the eq/gt/lt result.
interface serial_comparator_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;

  modport master (
    output start, a, b,
    input  busy, done, eq, gt, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, eq, gt, lt
  );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial N-bit unsigned magnitude/equality comparator.
// Operands are captured on start and then shifted out MSB-first, one bit
// per clock. The first bit position where A and B differ decides the
// result. Latency is always N+1 cycles from acceptance to the done pulse,
// because the bits keep shifting after a decision has been made.
module serial_comparator #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_comparator_if.slave bus
);

  // A single bit still needs a one-bit counter.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  sa, sb;
  logic [CW-1:0] cnt;
  logic          decided;
  logic          agt;

  logic bit_a, bit_b, e;
  logic first_diff;
  logic dec_nx, agt_nx;
  logic last;
  logic accept;

  // Per-bit equality stage and the decision that includes this cycle's bit.
  always_comb begin
    bit_a      = sa[N-1];
    bit_b      = sb[N-1];
    e          = ~(bit_a ^ bit_b);
    first_diff = ~decided & ~e;
    dec_nx     = decided | first_diff;
    agt_nx     = first_diff ? bit_a : agt;
    last       = (cnt == CW'(N - 1));
    // A new request is taken in IDLE and also in the DONE cycle.
    accept     = bus.start & (state != SHIFT);
  end

  // Control FSM: IDLE -> SHIFT (N cycles) -> DONE (1 cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state <= SHIFT;
        SHIFT:   if (last)      state <= DONE;
        DONE:    state <= bus.start ? SHIFT : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand shift registers, bit counter and first-difference tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      agt     <= 1'b0;
    end else if (accept) begin
      sa      <= bus.a;
      sb      <= bus.b;
      cnt     <= '0;
      decided <= 1'b0;
      agt     <= 1'b0;
    end else if (state == SHIFT) begin
      sa      <= sa << 1;
      sb      <= sb << 1;
      // Wraps harmlessly on the final bit; it is reloaded on acceptance.
      cnt     <= cnt + CW'(1);
      decided <= dec_nx;
      agt     <= agt_nx;
    end
  end

  // Registered handshake and result; results hold until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.eq   <= 1'b0;
      bus.gt   <= 1'b0;
      bus.lt   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        bus.busy <= 1'b1;
        bus.eq   <= 1'b0;
        bus.gt   <= 1'b0;
        bus.lt   <= 1'b0;
      end else if (state == SHIFT && last) begin
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.eq   <= ~dec_nx;
        bus.gt   <= dec_nx & agt_nx;
        bus.lt   <= dec_nx & ~agt_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: an N=8 and an N=1 instance side by side,
// directed scenarios plus random operands checked against plain unsigned
// comparison and the fixed N+1 cycle latency.
module tb_serial_comparator;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_comparator_if #(.N(8)) if8 ();
  serial_comparator_if #(.N(1)) if1 ();

  serial_comparator #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_comparator #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Reference result {eq, gt, lt} from plain unsigned comparison.
  function automatic logic [2:0] ref_cmp(input int unsigned x, input int unsigned y);
    return {x == y, x > y, x < y};
  endfunction

  // Pulse start for one edge on the selected instance (sel=1 -> N=1).
  // Returns at the negedge of the first cycle after acceptance.
  task automatic go(input bit sel, input logic [7:0] va, input logic [7:0] vb,
                    output int t0);
    logic [7:0] ta, tb;
    ta = va;
    tb = vb;
    @(negedge clk);
    if (sel) begin
      if1.start = 1'b1; if1.a = ta[0]; if1.b = tb[0];
    end else begin
      if8.start = 1'b1; if8.a = ta; if8.b = tb;
    end
    @(negedge clk);
    if1.start = 1'b0;
    if8.start = 1'b0;
    t0 = cyc;
  endtask

  // Wait (bounded) for done, scrambling operands meanwhile; report how many
  // cycles after the first post-accept cycle done appeared (-1 on timeout)
  // and whether busy was high in every cycle before it.
  task automatic wait_done(input bit sel, input int t0, output int lat,
                           output bit busy_ok);
    busy_ok = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (sel ? if1.done : if8.done) begin
        lat = cyc - t0;
        break;
      end
      if (!(sel ? if1.busy : if8.busy)) busy_ok = 1'b0;
      if8.a = 8'($urandom);
      if8.b = 8'($urandom);
      if1.a = 1'($urandom);
      if1.b = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({if8.busy, if8.done, if8.eq, if8.gt, if8.lt} !== 5'b0)
      $display("FAIL reset8 got %b want 00000", {if8.busy, if8.done, if8.eq, if8.gt, if8.lt});
    else pass_cnt++;
    chk_cnt++;
    if ({if1.busy, if1.done, if1.eq, if1.gt, if1.lt} !== 5'b0)
      $display("FAIL reset1 got %b want 00000", {if1.busy, if1.done, if1.eq, if1.gt, if1.lt});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  // Directed cases: equal, MSB decision, LSB-side decision with result hold.
  task automatic test_directed();
    logic [7:0] av [3] = '{8'hA5, 8'h80, 8'h01};
    logic [7:0] bv [3] = '{8'hA5, 8'h7F, 8'h02};
    int  t0, lat;
    bit  bok;
    bit  hold_ok;
    for (int i = 0; i < 3; i++) begin
      go(1'b0, av[i], bv[i], t0);
      wait_done(1'b0, t0, lat, bok);
      chk_cnt++;
      if (lat !== 8 || !bok)
        $display("FAIL dir%0d_timing lat %0d busy_ok %0d want 8 1", i, lat, bok);
      else pass_cnt++;
      chk_cnt++;
      if ({if8.busy, if8.eq, if8.gt, if8.lt} !== {1'b0, ref_cmp(av[i], bv[i])})
        $display("FAIL dir%0d_result got %b want %b", i,
                 {if8.busy, if8.eq, if8.gt, if8.lt}, {1'b0, ref_cmp(av[i], bv[i])});
      else pass_cnt++;
    end
    // 0x01 vs 0x02 is held with lt=1 while idle.
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({if8.done, if8.eq, if8.gt, if8.lt} !== 4'b0001) hold_ok = 1'b0;
    end
    chk_cnt++;
    if (!hold_ok)
      $display("FAIL hold got %b want 0001", {if8.done, if8.eq, if8.gt, if8.lt});
    else pass_cnt++;
  endtask

  // start while busy is ignored, start during done is accepted.
  task automatic test_back_to_back();
    int t0, t1, lat;
    bit bok;
    go(1'b0, 8'h10, 8'h20, t0);
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'h00;
    @(negedge clk);
    if8.start = 1'b0;
    wait_done(1'b0, t0, lat, bok);
    chk_cnt++;
    if (lat !== 8 || {if8.eq, if8.gt, if8.lt} !== 3'b001)
      $display("FAIL busy_ignore lat %0d res %b want 8 001", lat, {if8.eq, if8.gt, if8.lt});
    else pass_cnt++;
    // Request in the done cycle itself.
    if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'h00;
    @(negedge clk);
    if8.start = 1'b0;
    t1 = cyc;
    chk_cnt++;
    if ({if8.busy, if8.done, if8.eq, if8.gt, if8.lt} !== 5'b10000)
      $display("FAIL b2b_accept got %b want 10000", {if8.busy, if8.done, if8.eq, if8.gt, if8.lt});
    else pass_cnt++;
    wait_done(1'b0, t1, lat, bok);
    chk_cnt++;
    if (lat !== 8 || !bok || {if8.eq, if8.gt, if8.lt} !== 3'b010)
      $display("FAIL b2b_result lat %0d busy_ok %0d res %b want 8 1 010",
               lat, bok, {if8.eq, if8.gt, if8.lt});
    else pass_cnt++;
  endtask

  // Reset in the middle of a comparison discards it.
  task automatic test_mid_reset();
    int t0, lat;
    bit bok;
    bit seen;
    go(1'b0, 8'h33, 8'h33, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++;
    if ({if8.busy, if8.done, if8.eq, if8.gt, if8.lt} !== 5'b0)
      $display("FAIL midrst_clear got %b want 00000", {if8.busy, if8.done, if8.eq, if8.gt, if8.lt});
    else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if8.done || if8.busy) seen = 1'b1;
    end
    chk_cnt++;
    if (seen) $display("FAIL midrst_quiet got activity 1 want 0");
    else pass_cnt++;
    go(1'b0, 8'h5C, 8'h5D, t0);
    wait_done(1'b0, t0, lat, bok);
    chk_cnt++;
    if (lat !== 8 || !bok || {if8.eq, if8.gt, if8.lt} !== 3'b001)
      $display("FAIL midrst_after lat %0d busy_ok %0d res %b want 8 1 001",
               lat, bok, {if8.eq, if8.gt, if8.lt});
    else pass_cnt++;
  endtask

  // Single-bit instance: one SHIFT cycle, done two cycles after acceptance.
  task automatic test_n1();
    logic [7:0] av [3] = '{8'h1, 8'h0, 8'h1};
    logic [7:0] bv [3] = '{8'h0, 8'h1, 8'h1};
    int t0, lat;
    bit bok;
    for (int i = 0; i < 3; i++) begin
      go(1'b1, av[i], bv[i], t0);
      wait_done(1'b1, t0, lat, bok);
      chk_cnt++;
      if (lat !== 1 || !bok || {if1.eq, if1.gt, if1.lt} !== ref_cmp(av[i], bv[i]))
        $display("FAIL n1_%0d lat %0d busy_ok %0d res %b want 1 1 %b",
                 i, lat, bok, {if1.eq, if1.gt, if1.lt}, ref_cmp(av[i], bv[i]));
      else pass_cnt++;
    end
  endtask

  // Random operands on both widths, with equal pairs forced now and then.
  task automatic test_random();
    logic [7:0] ra, rb;
    int t0, lat;
    bit bok;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      go(1'b0, ra, rb, t0);
      wait_done(1'b0, t0, lat, bok);
      chk_cnt++;
      if (lat !== 8 || !bok || {if8.eq, if8.gt, if8.lt} !== ref_cmp(ra, rb))
        $display("FAIL rnd8 a=%h b=%h lat %0d busy_ok %0d res %b want 8 1 %b",
                 ra, rb, lat, bok, {if8.eq, if8.gt, if8.lt}, ref_cmp(ra, rb));
      else pass_cnt++;
      go(1'b1, ra, rb, t0);
      wait_done(1'b1, t0, lat, bok);
      chk_cnt++;
      if (lat !== 1 || {if1.eq, if1.gt, if1.lt} !== ref_cmp(ra[0], rb[0]))
        $display("FAIL rnd1 a=%b b=%b lat %0d res %b want 1 %b",
                 ra[0], rb[0], lat, {if1.eq, if1.gt, if1.lt}, ref_cmp(ra[0], rb[0]));
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_n1();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
